// File: rtl/fifo_drain_serializer_pkg.sv
// Shared types and constants for fifo_drain_serializer.
//   state_e    : serializer FSM states
//   DefDataW   : default FIFO word width
//   DefOutW    : default output beat width
//   cnt_width(): width of the beat counter for a given beats-per-word
package fifo_drain_serializer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StSend
  } state_e;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefOutW  = 8;

  // A counter always needs at least one bit, even when a word is a single beat.
  function automatic int unsigned cnt_width(input int unsigned nbeats);
    return (nbeats > 1) ? $clog2(nbeats) : 1;
  endfunction

endpackage

// File: rtl/fifo_drain_serializer_if.sv
// Bundle of the FIFO read-side and narrow output stream signals.
//   fifo_empty / fifo_re / fifo_rdata : FIFO read port (1-cycle read latency)
//   out_valid / out_ready / out_data / out_last : beat stream, valid/ready
//   busy : serializer not idle
// master: the serializer side; slave: FIFO plus downstream consumer side.
interface fifo_drain_serializer_if
  import fifo_drain_serializer_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned OUT_W  = DefOutW
) ();

  logic              fifo_empty;
  logic              fifo_re;
  logic [DATA_W-1:0] fifo_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;
  logic              busy;

  modport master (
    input  fifo_empty,
    output fifo_re,
    input  fifo_rdata,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last,
    output busy
  );

  modport slave (
    output fifo_empty,
    input  fifo_re,
    output fifo_rdata,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last,
    input  busy
  );

endinterface

// File: rtl/fifo_drain_serializer.sv
// Drains DATA_W-bit words from a synchronous FIFO and emits each one as
// DATA_W/OUT_W beats, least-significant slice first, on a valid/ready stream.
//   clk : clock, rising edge
//   rst : synchronous reset, active-high
//   bus : fifo_drain_serializer_if.master (FIFO read port, beat stream, busy)
// One bubble per word is spent waiting for the FIFO's registered read data.
module fifo_drain_serializer
  import fifo_drain_serializer_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned OUT_W  = DefOutW
) (
  input logic                     clk,
  input logic                     rst,
  fifo_drain_serializer_if.master bus
);

  localparam int unsigned NBEATS = DATA_W / OUT_W;
  localparam int unsigned CNT_W  = cnt_width(NBEATS);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NBEATS - 1);

  if ((OUT_W == 0) || (DATA_W % OUT_W != 0) || (NBEATS < 1)) begin : g_width_check
    $error("fifo_drain_serializer: DATA_W must be a non-zero multiple of OUT_W");
  end

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] w_shreg_nxt;
  logic              w_re;
  logic              w_valid;
  logic              w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shreg_nxt = r_shreg;
    w_re        = 1'b0;
    w_valid     = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!bus.fifo_empty) begin
          w_re        = 1'b1;
          w_state_nxt = StRdWait;
        end
      end
      StRdWait: begin
        // Read data is registered in the FIFO; it is valid in this cycle.
        w_shreg_nxt = bus.fifo_rdata;
        w_cnt_nxt   = '0;
        w_state_nxt = StSend;
      end
      StSend: begin
        w_valid = 1'b1;
        w_last  = (r_cnt == LastCnt);
        if (bus.out_ready) begin
          if (!w_last) begin
            w_shreg_nxt = r_shreg >> OUT_W;
            w_cnt_nxt   = r_cnt + 1'b1;
          end else if (!bus.fifo_empty) begin
            // Overlap the next read with the final beat to keep one bubble per word.
            w_re        = 1'b1;
            w_state_nxt = StRdWait;
          end else begin
            w_state_nxt = StIdle;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Gate with rst so a pending read never pops a word that reset would discard.
  assign bus.fifo_re   = w_re & ~rst;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_valid ? r_shreg[OUT_W-1:0] : '0;
  assign bus.out_last  = w_last;
  assign bus.busy      = (r_state != StIdle);

endmodule

// File: tb/tb_fifo_drain_serializer.sv
module tb_fifo_drain_serializer;
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 8;
  localparam int unsigned NB = DW / OW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_drain_serializer_if #(.DATA_W(DW), .OUT_W(OW)) bus ();

  fifo_drain_serializer #(.DATA_W(DW), .OUT_W(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // FIFO model: storage written by the stimulus, popped on fifo_re with 1-cycle latency.
  logic [DW-1:0] mem [0:4095];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          force_empty;

  assign bus.fifo_empty = (wr_ptr == rd_ptr) || force_empty;

  always @(posedge clk) begin
    if (bus.fifo_re) begin
      bus.fifo_rdata <= mem[rd_ptr[11:0]];
      rd_ptr         <= rd_ptr + 1;
    end
  end

  // Scoreboard queues: {last, data}
  logic [OW:0] exp_q[$];
  logic [OW:0] got_q[$];
  int          beat_cyc_q[$];
  int          re_cyc_q[$];

  int checks = 0;
  int errors = 0;

  // Monitor: samples at the falling edge, away from the active edge.
  int          cyc = 0;
  int          re_cnt = 0;
  int          re_empty_viol = 0;
  int          re_b2b_viol = 0;
  int          re_rst_cnt = 0;
  int          stable_viol = 0;
  int          valid_cnt = 0;

  initial begin : monitor
    logic        prev_re;
    logic        prev_stall;
    logic [OW:0] prev_beat;
    prev_re    = 1'b0;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.fifo_re === 1'b1) begin
        re_cnt++;
        re_cyc_q.push_back(cyc);
        if (bus.fifo_empty) re_empty_viol++;
        if (prev_re) re_b2b_viol++;
        if (rst) re_rst_cnt++;
      end
      prev_re = (bus.fifo_re === 1'b1);
      if (!rst) begin
        if (bus.out_valid) valid_cnt++;
        if (prev_stall && (!bus.out_valid || ({bus.out_last, bus.out_data} !== prev_beat)))
          stable_viol++;
        if (bus.out_valid && bus.out_ready) begin
          got_q.push_back({bus.out_last, bus.out_data});
          beat_cyc_q.push_back(cyc);
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_beat  = {bus.out_last, bus.out_data};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_push(input logic [DW-1:0] w);
    logic lb;
    mem[wr_ptr[11:0]] = w;
    wr_ptr++;
    for (int b = 0; b < int'(NB); b++) begin
      lb = (b == int'(NB) - 1);
      exp_q.push_back({lb, w[b*OW +: OW]});
    end
  endtask

  task automatic clear_obs();
    got_q.delete();
    beat_cyc_q.delete();
    re_cyc_q.delete();
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    for (int i = 0; i < budget && got_q.size() < n; i++) tick();
    checks++;
    if (got_q.size() < n) begin
      errors++;
      $display("FAIL %s timeout: beats got %0d required %0d", name, got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b0;
    force_empty = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.fifo_re, bus.out_valid, bus.out_data, bus.out_last, bus.busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got re=%b v=%b d=%h l=%b busy=%b required all 0",
               bus.fifo_re, bus.out_valid, bus.out_data, bus.out_last, bus.busy);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy got %b required 0", bus.busy);
    end
  endtask

  task automatic test_empty();
    int re0, v0;
    clear_obs();
    re0 = re_cnt;
    v0  = valid_cnt;
    repeat (50) tick();
    checks++;
    if (re_cnt != re0) begin
      errors++;
      $display("FAIL empty_no_re: pulses got %0d required 0", re_cnt - re0);
    end
    checks++;
    if (valid_cnt != v0) begin
      errors++;
      $display("FAIL empty_no_valid: valid cycles got %0d required 0", valid_cnt - v0);
    end
  endtask

  task automatic test_single();
    int re0;
    logic [OW:0] g, e;
    clear_obs();
    re0 = re_cnt;
    bus.out_ready = 1'b1;
    fifo_push(32'hA1B2C3D4);
    wait_beats(4, 40, "single");
    repeat (3) tick();
    checks++;
    if (re_cnt - re0 != 1) begin
      errors++;
      $display("FAIL single_re_count: got %0d required 1", re_cnt - re0);
    end
    if (beat_cyc_q.size() == 4 && re_cyc_q.size() >= 1) begin
      checks++;
      if (beat_cyc_q[0] != re_cyc_q[0] + 2 || beat_cyc_q[3] != beat_cyc_q[0] + 3) begin
        errors++;
        $display("FAIL single_timing: first beat at +%0d span %0d required +2 span 3",
                 beat_cyc_q[0] - re_cyc_q[0], beat_cyc_q[3] - beat_cyc_q[0]);
      end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL single_beat: got last=%b data=%h required last=%b data=%h",
                 g[OW], g[OW-1:0], e[OW], e[OW-1:0]);
      end
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b valid=%b required 0 0", bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    int re0;
    logic pat [4];
    logic [OW:0] g, e;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    clear_obs();
    re0 = re_cnt;
    stable_viol = 0;
    fifo_push(32'hA1B2C3D4);
    for (int i = 0; i < 80 && got_q.size() < 4; i++) begin
      bus.out_ready = pat[i % 4];
      tick();
    end
    bus.out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL bp_count: beats got %0d required 4", got_q.size());
    end
    checks++;
    if (stable_viol != 0) begin
      errors++;
      $display("FAIL bp_stable: violations got %0d required 0", stable_viol);
    end
    checks++;
    if (re_cnt - re0 != 1) begin
      errors++;
      $display("FAIL bp_re_count: got %0d required 1", re_cnt - re0);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL bp_beat: got last=%b data=%h required last=%b data=%h",
                 g[OW], g[OW-1:0], e[OW], e[OW-1:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [OW:0] g, e;
    clear_obs();
    bus.out_ready = 1'b1;
    fifo_push(32'h11223344);
    fifo_push(32'h55667788);
    wait_beats(8, 60, "b2b");
    repeat (3) tick();
    if (beat_cyc_q.size() == 8 && re_cyc_q.size() == 2) begin
      checks++;
      if (re_cyc_q[1] != beat_cyc_q[3]) begin
        errors++;
        $display("FAIL b2b_overlap: second re at %0d required %0d", re_cyc_q[1], beat_cyc_q[3]);
      end
      checks++;
      if (beat_cyc_q[7] - re_cyc_q[0] != 10 || beat_cyc_q[4] - beat_cyc_q[3] != 2) begin
        errors++;
        $display("FAIL b2b_timing: total %0d gap %0d required 10 2",
                 beat_cyc_q[7] - re_cyc_q[0], beat_cyc_q[4] - beat_cyc_q[3]);
      end
    end else begin
      checks++;
      errors++;
      $display("FAIL b2b_counts: beats %0d re %0d required 8 2", beat_cyc_q.size(),
               re_cyc_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL b2b_beat: got last=%b data=%h required last=%b data=%h",
                 g[OW], g[OW-1:0], e[OW], e[OW-1:0]);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    int rr0;
    logic [OW:0] g, e;
    clear_obs();
    rr0 = re_rst_cnt;
    bus.out_ready = 1'b1;
    fifo_push(32'hDEADBEEF);
    wait_beats(2, 40, "rst_mid");
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.fifo_re, bus.out_valid, bus.out_data, bus.out_last, bus.busy} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got re=%b v=%b d=%h l=%b busy=%b required all 0",
               bus.fifo_re, bus.out_valid, bus.out_data, bus.out_last, bus.busy);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL rst_mid_pre: got last=%b data=%h required last=%b data=%h",
                 g[OW], g[OW-1:0], e[OW], e[OW-1:0]);
      end
    end
    exp_q.delete();
    fifo_push(32'hCAFEF00D);
    repeat (2) tick();
    checks++;
    if (re_rst_cnt != rr0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold: re pulses %0d busy %b required 0 0", re_rst_cnt - rr0, bus.busy);
    end
    rst = 1'b0;
    wait_beats(4, 40, "rst_after");
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL rst_after_beat: got last=%b data=%h required last=%b data=%h",
                 g[OW], g[OW-1:0], e[OW], e[OW-1:0]);
      end
    end
  endtask

  task automatic test_random();
    int pushed, seen;
    logic [OW:0] g, e;
    clear_obs();
    re_empty_viol = 0;
    re_b2b_viol   = 0;
    stable_viol   = 0;
    pushed = 0;
    seen   = 0;
    for (int i = 0; i < 40000 && seen < 1000 * int'(NB); i++) begin
      if (pushed < 1000 && (wr_ptr - rd_ptr) < 4 && $urandom_range(1, 0) == 1) begin
        fifo_push($urandom());
        pushed++;
      end
      bus.out_ready = ($urandom_range(9, 0) < 6);
      force_empty   = ($urandom_range(4, 0) == 0);
      tick();
      while (got_q.size() > 0) begin
        g = got_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: got last=%b data=%h with nothing expected", g[OW],
                   g[OW-1:0]);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            errors++;
            $display("FAIL rand_beat %0d: got last=%b data=%h required last=%b data=%h",
                     seen, g[OW], g[OW-1:0], e[OW], e[OW-1:0]);
          end
        end
        seen++;
      end
    end
    force_empty   = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (seen != 1000 * int'(NB)) begin
      errors++;
      $display("FAIL rand_count: beats got %0d required %0d", seen, 1000 * NB);
    end
    checks++;
    if (re_empty_viol != 0 || re_b2b_viol != 0) begin
      errors++;
      $display("FAIL rand_re_rules: re-while-empty %0d back-to-back %0d required 0 0",
               re_empty_viol, re_b2b_viol);
    end
    checks++;
    if (stable_viol != 0) begin
      errors++;
      $display("FAIL rand_stable: violations got %0d required 0", stable_viol);
    end
  endtask

  initial begin
    rst           = 1'b1;
    force_empty   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_empty();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_drain_serializer.md
Name: fifo_drain_serializer

Overview:
Read-side consumer for the team's synchronous FIFO. It pops DATA_W-bit words through the FIFO's re/Empty interface and captures each word from the FIFO's registered read data. It then emits each word as DATA_W/OUT_W narrow beats, LSB slice first, on a valid/ready output stream. It sits between the FIFO and a narrow link or UART-style transmitter.

Parameters:
DATA_W, 32, FIFO word width; must be an integer multiple of OUT_W
OUT_W, 8, output beat width
NBEATS, DATA_W/OUT_W (derived localparam), beats per word; must be ≥1

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
fifo_empty  input  1  FIFO Empty flag
fifo_re  output  1  FIFO read enable, one-cycle pulse per word
fifo_rdata  input  DATA_W  FIFO data_out, valid the cycle after fifo_re is sampled
out_valid  output  1  beat valid
out_ready  input  1  downstream accepts beat
out_data  output  OUT_W  current beat
out_last  output  1  high with the final beat of a word
busy  output  1  high whenever state != IDLE

Behaviour:
- Interface decision: reset rst, synchronous, active-high; clock clk.
- Reset values: fifo_re=0, out_valid=0, out_data=0, out_last=0, busy=0, state=IDLE, beat count=0, shift register=0.
- fifo_re is combinational from state and fifo_empty. It is never high while fifo_empty=1, and never high in two consecutive cycles.
- FIFO read latency is 1: if fifo_re=1 at edge k, fifo_rdata is valid in cycle k+1 and is captured at edge k+1.
- States:
  - IDLE:
    - fifo_empty=0: fifo_re=1, next state RD_WAIT.
    - Otherwise remain in IDLE.
  - RD_WAIT:
    - Load shreg<=fifo_rdata and cnt<=0, next state SEND.
    - out_valid=0 in this state.
  - SEND:
    - out_valid=1, out_data=shreg[OUT_W-1:0], out_last=(cnt==NBEATS-1).
    - Handshake (out_valid&&out_ready) on a non-last beat: shreg shifts right by OUT_W (zero fill), cnt<=cnt+1, stay in SEND.
    - Handshake on the last beat with fifo_empty=0: fifo_re=1 in the same cycle, next state RD_WAIT.
    - Handshake on the last beat with fifo_empty=1: next state IDLE.
    - No handshake: remain in SEND.
- Stream rules:
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - out_valid does not deassert until the beat is accepted.
  - out_valid does not depend combinationally on out_ready.
- Throughput: NBEATS+1 cycles per word under continuous ready and non-empty FIFO, i.e. one bubble per word for the read latency.
- Boundary cases:
  - fifo_empty falling in the same cycle as the last beat is sampled as-is; no read is issued when empty=1.
  - NBEATS=1: every beat is last.
  - cnt width is max(1,$clog2(NBEATS)).
- Reset mid-word: the word in progress is discarded (bytes already popped from the FIFO are lost). out_valid=0 from the cycle after the reset edge; no fifo_re is issued during reset.

Decomposition:
- Package fifo_drain_pkg:
  - state enum {IDLE, RD_WAIT, SEND}
  - default width constants
  - function computing the counter width
- No sub-module is needed: a single FSM plus a shift register and a counter.
- Elaboration-time check: DATA_W%OUT_W==0.

Test Plan:
1. FIFO model holds 0xA1B2C3D4, out_ready=1 → exactly one fifo_re pulse; beats D4,C3,B2,A1 on consecutive cycles starting 2 cycles after the pulse; out_last only on A1; then IDLE, busy=0.
2. Same word, out_ready toggling 1,0,0,1,… → each beat held stable while ready=0; 4 beats delivered in order; no extra fifo_re.
3. FIFO holds 0x11223344 and 0x55667788, out_ready=1 → second fifo_re coincides with the acceptance of 0x11; output is 44,33,22,11,(bubble),88,77,66,55; 10 cycles total.
4. fifo_empty=1 for 50 cycles after reset → fifo_re never asserts; out_valid stays 0.
5. rst asserted after the 2nd beat of 0xDEADBEEF → next cycle out_valid=0 and all outputs at reset values; after release with the FIFO holding 0xCAFEF00D, the output is 0D,F0,FE,CA.
6. Randomized ready/empty for 1000 words, checked by a scoreboard → every fifo_re pulse occurs while empty=0; byte stream equals the popped words, LSB first.
